// File: rtl/as5600_i2c_target_pkg.sv
// as5600_i2c_target_pkg: AS5600 register map, FSM states and read-mux helper
package as5600_i2c_target_pkg;
  localparam logic [7:0] REG_STATUS = 8'h0B;
  localparam logic [7:0] REG_RAW_HI = 8'h0C;
  localparam logic [7:0] REG_RAW_LO = 8'h0D;
  localparam logic [7:0] REG_ANG_HI = 8'h0E;
  localparam logic [7:0] REG_ANG_LO = 8'h0F;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA, S_TX, S_IGNORE} state_t;
  function automatic logic [7:0] rd_byte(input logic [7:0] a, input logic [11:0] ang, input logic mok);
    return (a == REG_STATUS) ? {2'b0, mok, 5'b0} :
           (a == REG_RAW_HI || a == REG_ANG_HI) ? {4'h0, ang[11:8]} :
           (a == REG_RAW_LO || a == REG_ANG_LO) ? ang[7:0] : 8'h00;
  endfunction
endpackage

// File: rtl/as5600_i2c_target_line_filter.sv
// as5600_i2c_target_line_filter: 2-FF sync, glitch filter and edge detect for one I2C line
//  clk, rst_n : system clock, async active-low reset
//  din        : raw line level
//  lvl        : filtered level (idle high)
//  rise, fall : one-cycle pulses coincident with the filtered level change
module as5600_i2c_target_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [2:0] cnt;
  logic accept;
  // a change is taken once the synced level has differed for FILTER_LEN samples in a row
  assign accept = (sync[1] != lvl) && (cnt == 3'(FILTER_LEN - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= 3'd0;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= accept & sync[1];
      fall <= accept & ~sync[1];
      cnt  <= (sync[1] == lvl || accept) ? 3'd0 : cnt + 3'd1;
      if (accept) lvl <= sync[1];
    end
endmodule

// File: rtl/as5600_i2c_target.sv
// as5600_i2c_target: I2C target emulating the AS5600 STATUS/RAW ANGLE/ANGLE registers
//  I_clk, I_rstn       : system clock (>= 16x SCL), async active-low reset
//  I_i2c_scl           : SCL from initiator, never stretched
//  IO_i2c_sda          : open-drain SDA, driven 0 or Z
//  I_angle, I_magnet_ok: live angle and magnet-detect served to reads
//  O_busy              : START..STOP
//  O_wr_valid/addr/data: one pulse per host-written data byte
//  O_rd_done           : pulse when the host NACKs a read byte
module as5600_i2c_target
  import as5600_i2c_target_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h36,
  parameter int         FILTER_LEN = 3
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_i2c_scl,
  inout  wire         IO_i2c_sda,
  input  logic [11:0] I_angle,
  input  logic        I_magnet_ok,
  output logic        O_busy,
  output logic        O_wr_valid,
  output logic [7:0]  O_wr_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rd_done
);
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop, live, rw, ack, oe;
  logic [3:0] cnt;
  logic [7:0] sh, txb, ptr, nb;
  logic [11:0] shadow;
  state_t state;
  as5600_i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(I_clk), .rst_n(I_rstn), .din(I_i2c_scl), .lvl(scl), .rise(scl_rise), .fall(scl_fall));
  as5600_i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(I_clk), .rst_n(I_rstn), .din(IO_i2c_sda), .lvl(sda), .rise(sda_rise), .fall(sda_fall));
  assign IO_i2c_sda = oe ? 1'b0 : 1'bz;
  assign start  = sda_fall & scl;
  assign stop   = sda_rise & scl;
  assign live   = state != S_IDLE && state != S_IGNORE;
  assign O_busy = state != S_IDLE;
  // first byte of a read comes from the live angle (captured into shadow on the same edge),
  // follow-on bytes come from the shadow at the advanced pointer
  always_comb nb = (state == S_TX) ? rd_byte(ptr + 8'd1, shadow, I_magnet_ok) : rd_byte(ptr, I_angle, I_magnet_ok);
  always_ff @(posedge I_clk or negedge I_rstn)
    if (!I_rstn) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      sh         <= 8'h00;
      txb        <= 8'h00;
      ptr        <= 8'h00;
      shadow     <= 12'h000;
      rw         <= 1'b0;
      ack        <= 1'b1;
      oe         <= 1'b0;
      O_wr_valid <= 1'b0;
      O_wr_addr  <= 8'h00;
      O_wr_data  <= 8'h00;
      O_rd_done  <= 1'b0;
    end else begin
      O_wr_valid <= 1'b0;
      O_rd_done  <= 1'b0;
      if (start) begin
        state <= S_ADDR;
        cnt   <= 4'd0;
        oe    <= 1'b0;
      end else if (stop) begin
        state <= S_IDLE;
        oe    <= 1'b0;
      end else if (live && scl_rise) begin
        // the ninth clock samples the ACK bit and leaves the received byte intact
        if (cnt == 4'd8) ack <= sda;
        else sh <= {sh[6:0], sda};
        cnt <= cnt + 4'd1;
      end else if (live && scl_fall) begin
        unique case (state)
          S_ADDR: if (cnt == 4'd8) begin
            if (sh[7:1] == SLAVE_ADDR) begin
              state <= S_ADDR_ACK;
              rw    <= sh[0];
              oe    <= 1'b1;
            end else state <= S_IGNORE;
          end
          S_ADDR_ACK: if (cnt == 4'd9) begin
            cnt <= 4'd0;
            if (rw) begin
              shadow <= I_angle;
              state  <= S_TX;
              oe     <= ~nb[7];
              txb    <= {nb[6:0], 1'b0};
            end else begin
              state <= S_PTR;
              oe    <= 1'b0;
            end
          end
          S_PTR: if (cnt == 4'd8) oe <= 1'b1;
          else if (cnt == 4'd9) begin
            cnt   <= 4'd0;
            oe    <= 1'b0;
            ptr   <= sh;
            state <= S_WDATA;
          end
          S_WDATA: if (cnt == 4'd8) oe <= 1'b1;
          else if (cnt == 4'd9) begin
            cnt        <= 4'd0;
            oe         <= 1'b0;
            O_wr_valid <= 1'b1;
            O_wr_addr  <= ptr;
            O_wr_data  <= sh;
            ptr        <= ptr + 8'd1;
          end
          S_TX: if (cnt == 4'd8) oe <= 1'b0;
          else if (cnt == 4'd9) begin
            cnt <= 4'd0;
            if (ack) begin
              O_rd_done <= 1'b1;
              state     <= S_IGNORE;
            end else begin
              ptr <= ptr + 8'd1;
              oe  <= ~nb[7];
              txb <= {nb[6:0], 1'b0};
            end
          end else begin
            oe  <= ~txb[7];
            txb <= {txb[6:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
endmodule
